seq_divider: RTL and testbench

Sequential restoring divider for unsigned N-bit operands. It is the inverse-operation counterpart of the team's combinational ripple adder/subtractor. Each iteration performs one trial subtraction (add of inverted divisor with carry-in 1) and keeps or discards the result based on carry-out. It sits beside the adder/subtractor in the arithmetic lab datapath and uses a start/busy/done handshake toward the controlling FSM.

---
 rtl/seq_divider.sv | 109 ++++++++++
 tb/tb_seq_divider.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider for unsigned N-bit operands.
// Start/busy/done handshake; each RUN cycle retires one quotient bit via a trial subtraction.
module seq_divider #(
  parameter int unsigned N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_q,
  output logic [N-1:0] o_r,
  output logic         o_dz
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         r_state;
  logic [N-1:0]   r_y;
  logic [N:0]     r_p;
  logic [N-1:0]   r_qs;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [N-1:0]   r_q;
  logic [N-1:0]   r_r;
  logic           r_dz;

  logic [2*N:0]   w_pq_sh;
  logic [N:0]     w_p_sh;
  logic [N+1:0]   w_sum;
  logic           w_cout;
  logic [N:0]     w_p_nx;
  logic [N-1:0]   w_q_nx;

  // Trial subtraction P - Y as P + ~{0,Y} + 1; carry-out set means no borrow.
  always_comb begin
    w_pq_sh = {r_p, r_qs} << 1;
    w_p_sh  = w_pq_sh[2*N:N];
    w_sum   = {1'b0, w_p_sh} + {1'b0, ~{1'b0, r_y}} + {{(N+1){1'b0}}, 1'b1};
    w_cout  = w_sum[N+1];
    w_p_nx  = w_cout ? w_sum[N:0] : w_p_sh;
    w_q_nx  = {w_pq_sh[N-1:1], w_cout};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_y     <= '0;
      r_p     <= '0;
      r_qs    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          r_done <= 1'b0;
          if (i_start) begin
            if (i_y != '0) begin
              r_y     <= i_y;
              r_p     <= '0;
              r_qs    <= i_x;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= StRun;
            end else begin
              r_q     <= '1;
              r_r     <= i_x;
              r_dz    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= StDone;
            end
          end else begin
            r_state <= StIdle;
          end
        end
        StRun: begin
          r_p   <= w_p_nx;
          r_qs  <= w_q_nx;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(N - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_q     <= w_q_nx;
            r_r     <= w_p_nx[N-1:0];
            r_dz    <= 1'b0;
            r_state <= StDone;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_q    = r_q;
  assign o_r    = r_r;
  assign o_dz   = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, corner-case sequences and an
// exhaustive back-to-back sweep, with a result scoreboard popped on every done pulse.
module tb_seq_divider;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] x = '0;
  logic [N-1:0] y = '0;
  logic         busy, done, dz;
  logic [N-1:0] q, r;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } exp_t;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  exp_t sb[$];

  seq_divider #(.N(N)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .i_x    (x),
    .i_y    (y),
    .o_busy (busy),
    .o_done (done),
    .o_q    (q),
    .o_r    (r),
    .o_dz   (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    check("busy_done_exclusive", int'(busy & done), 0);
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_q", int'(q), int'(e.q));
        check("sb_r", int'(r), int'(e.r));
        check("sb_dz", int'(dz), int'(e.dz));
      end
    end
  end

  // Issue one start (state must be IDLE or DONE) and wait for its done pulse.
  task automatic run_one(input logic [N-1:0] xi, input logic [N-1:0] yi,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic edz, input int elat, input logic chk_busy);
    int n;
    int nb;
    exp_t e;
    e.q = eq;
    e.r = er;
    e.dz = edz;
    sb.push_back(e);
    x = xi;
    y = yi;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    nb = busy ? 1 : 0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (busy) nb++;
    end
    check("latency", n, elat);
    if (chk_busy) check("busy_cycles", nb, (elat == 1) ? 0 : int'(N));
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{x: 4'd13, y: 4'd3,  q: 4'd4,  r: 4'd1, dz: 1'b0, lat: 5};
    vecs[1] = '{x: 4'd15, y: 4'd1,  q: 4'd15, r: 4'd0, dz: 1'b0, lat: 5};
    vecs[2] = '{x: 4'd5,  y: 4'd7,  q: 4'd0,  r: 4'd5, dz: 1'b0, lat: 5};
    vecs[3] = '{x: 4'd15, y: 4'd15, q: 4'd1,  r: 4'd0, dz: 1'b0, lat: 5};
    vecs[4] = '{x: 4'd9,  y: 4'd0,  q: 4'd15, r: 4'd9, dz: 1'b1, lat: 1};
    vecs[5] = '{x: 4'd7,  y: 4'd2,  q: 4'd3,  r: 4'd1, dz: 1'b0, lat: 5};
    vecs[6] = '{x: 4'd0,  y: 4'd5,  q: 4'd0,  r: 4'd0, dz: 1'b0, lat: 5};

    // Reset values
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(q), 0);
    check("rst_r", int'(r), 0);
    check("rst_dz", int'(dz), 0);

    // Vector table, each followed by idle cycles where results must hold
    for (int i = 0; i < 7; i++) begin
      run_one(vecs[i].x, vecs[i].y, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat, 1'b1);
      x = ~vecs[i].x;
      y = ~vecs[i].y;
      tick();
      tick();
      check("hold_done", int'(done), 0);
      check("hold_q", int'(q), int'(vecs[i].q));
      check("hold_r", int'(r), int'(vecs[i].r));
      check("hold_dz", int'(dz), int'(vecs[i].dz));
    end

    // start held through RUN with operands changed: only the DONE cycle re-samples
    begin
      exp_t e;
      int n;
      e.q = 4'd2; e.r = 4'd2; e.dz = 1'b0;
      sb.push_back(e);
      e.q = 4'd3; e.r = 4'd0; e.dz = 1'b0;
      sb.push_back(e);
      x = 4'd12;
      y = 4'd5;
      start = 1'b1;
      tick();
      x = 4'd3;
      y = 4'd1;
      n = 1;
      while (!done && n < 20) begin
        tick();
        n++;
      end
      check("held_first_lat", n, 5);
      tick();
      start = 1'b0;
      check("held_restart_busy", int'(busy), 1);
      n = 1;
      while (!done && n < 20) begin
        tick();
        n++;
      end
      check("held_spacing", n, 5);
      tick();
    end

    // Reset in the second RUN cycle discards the division
    x = 4'd7;
    y = 4'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("midrun_busy_before", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_busy", int'(busy), 0);
    check("midrun_done", int'(done), 0);
    check("midrun_q", int'(q), 0);
    check("midrun_r", int'(r), 0);
    check("midrun_dz", int'(dz), 0);
    tick();
    check("midrun_no_done", int'(done), 0);
    run_one(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 5, 1'b1);

    // Exhaustive back-to-back sweep: next start issued in each DONE cycle
    for (int i = 0; i < 256; i++) begin
      logic [N-1:0] xs;
      logic [N-1:0] ys;
      logic [N-1:0] eq;
      logic [N-1:0] er;
      xs = 4'(i >> 4);
      ys = 4'(i);
      if (ys == '0) begin
        eq = '1;
        er = xs;
      end else begin
        eq = xs / ys;
        er = xs % ys;
      end
      run_one(xs, ys, eq, er, (ys == '0), (ys == '0) ? 1 : 5, 1'b0);
    end
    tick();
    tick();
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
